// File: rtl/rcon_seq.sv
// rcon_seq: sequential AES key-expansion round-constant generator.
// Steps the Rcon byte through GF(2^8) (modulo 0x11B) instead of using a
// round-indexed lookup, and hands each constant out on a valid/next handshake.
// The optional inverse walk, for on-the-fly decryption key schedules, is
// compiled in when the macro RCON_INVERSE_EN is defined. Without it, dir is
// ignored and every sequence runs forward.
module rcon_seq #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        key_size,
  input  logic              dir,
  input  logic              next,
  output logic [WORD_W-1:0] rcon,
  output logic              rcon_valid,
  output logic [3:0]        round,
  output logic              last,
  output logic              done,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q,  byte_d;
  logic [3:0] round_q, round_d;
  logic [3:0] len_q,   len_d;
  logic       last_q,  last_d;
  logic       valid_q, valid_d;
  logic       done_q,  done_d;

  // Multiply by x in GF(2^8): shift left, fold bit 8 back with 0x1B.
  function automatic logic [7:0] fwd_step(input logic [7:0] b);
    fwd_step = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Number of constants consumed by each key size; the reserved code
  // 11 behaves like AES-128.
  function automatic logic [3:0] len_of(input logic [1:0] ks);
    case (ks)
      2'b01:   len_of = 4'd8;
      2'b10:   len_of = 4'd7;
      default: len_of = 4'd10;
    endcase
  endfunction

`ifdef RCON_INVERSE_EN
  logic inv_q, inv_d;

  // Divide by x in GF(2^8): undo the 0x1B fold when the low bit shows
  // that the forward step reduced.
  function automatic logic [7:0] inv_step(input logic [7:0] b);
    if (b[0]) inv_step = ((b ^ 8'h1B) >> 1) | 8'h80;
    else      inv_step = b >> 1;
  endfunction

  // Final forward constant for a given length; the inverse walk begins here.
  function automatic logic [7:0] inv_seed(input logic [3:0] len);
    case (len)
      4'd8:    inv_seed = 8'h80;
      4'd7:    inv_seed = 8'h40;
      default: inv_seed = 8'h36;
    endcase
  endfunction
`else
  // dir stays on the port list so both builds share one interface.
  logic unused_dir;
  assign unused_dir = dir;
`endif

  // Next-state, next-constant and registered-output computation.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    round_d = round_q;
    len_d   = len_q;
    last_d  = last_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef RCON_INVERSE_EN
    inv_d   = inv_q;
`endif

    if (start) begin
      // start wins in every state; a RUN abort produces no done pulse.
      state_d = S_RUN;
      valid_d = 1'b1;
      len_d   = len_of(key_size);
      last_d  = 1'b0;
`ifdef RCON_INVERSE_EN
      inv_d   = dir;
      byte_d  = dir ? inv_seed(len_d) : 8'h01;
      round_d = dir ? len_d : 4'd1;
`else
      byte_d  = 8'h01;
      round_d = 4'd1;
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (next && valid_q) begin
            if (last_q) begin
              // Final constant accepted: drop the outputs to idle zeros.
              state_d = S_DONE;
              valid_d = 1'b0;
              byte_d  = 8'h00;
              round_d = 4'd0;
              last_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
`ifdef RCON_INVERSE_EN
              if (inv_q) begin
                byte_d  = inv_step(byte_q);
                round_d = round_q - 4'd1;
                last_d  = (round_d == 4'd1);
              end else begin
                byte_d  = fwd_step(byte_q);
                round_d = round_q + 4'd1;
                last_d  = (round_d == len_q);
              end
`else
              byte_d  = fwd_step(byte_q);
              round_d = round_q + 4'd1;
              last_d  = (round_d == len_q);
`endif
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset forces the idle, all-zero view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      byte_q  <= 8'h00;
      round_q <= 4'd0;
      len_q   <= 4'd10;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      round_q <= round_d;
      len_q   <= len_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef RCON_INVERSE_EN
  // Direction latched with start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end
`endif

  // Place the byte in the top lane of the word; byte_q is already zero
  // whenever no constant is live.
  always_comb begin
    rcon = '0;
    rcon[WORD_W-1 -: 8] = byte_q;
  end

  assign rcon_valid = valid_q;
  assign round      = round_q;
  assign last       = last_q;
  assign done       = done_q;
  assign busy       = valid_q;

endmodule

// File: tb/tb_rcon_seq.sv
// Bench for rcon_seq: a 32-bit and an 8-bit instance run side by side on
// shared inputs, with a scoreboard queue of expected constants.
module tb_rcon_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  key_size;
  logic        dir;
  logic        next;
  logic [31:0] rcon32;
  logic        valid32, last32, done32, busy32;
  logic [3:0]  round32;
  logic [7:0]  rcon8;
  logic        valid8, last8, done8, busy8;
  logic [3:0]  round8;

  always #5 clk = ~clk;

  rcon_seq #(.WORD_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .dir(dir),
    .next(next), .rcon(rcon32), .rcon_valid(valid32), .round(round32),
    .last(last32), .done(done32), .busy(busy32)
  );

  rcon_seq #(.WORD_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_size(key_size), .dir(dir),
    .next(next), .rcon(rcon8), .rcon_valid(valid8), .round(round8),
    .last(last8), .done(done8), .busy(busy8)
  );

  typedef struct {
    logic [7:0] b;
    logic [3:0] rnd;
    logic       lst;
  } exp_t;

  typedef struct {
    logic [1:0] ks;
    logic       dv;
    bit         rnd_next;
  } vec_t;

  exp_t       sb[$];
  logic [7:0] fwd_tab [10];
  vec_t       vecs [7];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic done_req);
    chk({tag, " rcon32"}, rcon32, 32'h0);
    chk({tag, " rcon8"}, {24'h0, rcon8}, 32'h0);
    chk({tag, " valid"}, {30'h0, valid32, valid8}, 32'h0);
    chk({tag, " busy"}, {30'h0, busy32, busy8}, 32'h0);
    chk({tag, " round"}, {24'h0, round32, round8}, 32'h0);
    chk({tag, " last"}, {30'h0, last32, last8}, 32'h0);
    chk({tag, " done"}, {30'h0, done32, done8}, {30'h0, done_req, done_req});
  endtask

  task automatic chk_live(input exp_t e);
    chk("live valid", {30'h0, valid32, valid8}, 32'h3);
    chk("live busy", {30'h0, busy32, busy8}, 32'h3);
    chk("live rcon32", rcon32, {e.b, 24'h0});
    chk("live rcon8", {24'h0, rcon8}, {24'h0, e.b});
    chk("live round", {24'h0, round32, round8}, {24'h0, e.rnd, e.rnd});
    chk("live last", {30'h0, last32, last8}, {30'h0, e.lst, e.lst});
    chk("live done", {30'h0, done32, done8}, 32'h0);
  endtask

  // Queue the expected constants for one sequence from the reference table.
  task automatic push_seq(input logic [1:0] ks, input logic dv);
    int  len;
    bit  inv;
    exp_t e;
    len = (ks == 2'b01) ? 8 : (ks == 2'b10) ? 7 : 10;
`ifdef RCON_INVERSE_EN
    inv = dv;
`else
    inv = 1'b0;
    if (dv) inv = 1'b0;
`endif
    for (int i = 0; i < len; i++) begin
      e.b   = fwd_tab[inv ? (len - 1 - i) : i];
      e.rnd = 4'(inv ? (len - i) : (i + 1));
      e.lst = (i == len - 1);
      sb.push_back(e);
    end
  endtask

  // Drain the scoreboard: one constant popped per accepted handshake.
  task automatic drain(input bit rnd_next);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (sb.size() > 0 && cyc < 400) begin
      chk_live(sb[0]);
      next = rnd_next ? 1'($urandom_range(0, 1)) : 1'b1;
      if (next) e = sb.pop_front();
      cycle();
      cyc++;
    end
    chk("drain timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_start(input logic [1:0] ks, input logic dv);
    start    = 1'b1;
    key_size = ks;
    dir      = dv;
    next     = 1'b0;
    cycle();
    start    = 1'b0;
    key_size = 2'($urandom_range(0, 3));
    dir      = 1'($urandom_range(0, 1));
  endtask

  initial begin
    exp_t e;
    fwd_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    vecs = '{
      '{2'b00, 1'b0, 1'b0},
      '{2'b01, 1'b0, 1'b0},
      '{2'b10, 1'b0, 1'b0},
      '{2'b11, 1'b0, 1'b0},
      '{2'b00, 1'b0, 1'b1},
      '{2'b00, 1'b1, 1'b0},
      '{2'b10, 1'b1, 1'b1}
    };

    rst_n = 1'b0; start = 1'b0; key_size = 2'b00; dir = 1'b0; next = 1'b0;
    #12;
    chk_idle("reset", 1'b0);
    rst_n = 1'b1;
    cycle();

    // next while idle does nothing.
    next = 1'b1;
    cycle(); cycle();
    chk_idle("idle next", 1'b0);
    next = 1'b0;

    // Table-driven sequences.
    foreach (vecs[v]) begin
      push_seq(vecs[v].ks, vecs[v].dv);
      do_start(vecs[v].ks, vecs[v].dv);
      drain(vecs[v].rnd_next);
      next = 1'b0;
      chk_idle("done pulse", 1'b1);
      cycle();
      chk_idle("after done", 1'b0);
      cycle();
    end

    // Restart at round 5: reload without a done pulse.
    do_start(2'b00, 1'b0);
    next = 1'b1;
    repeat (4) cycle();
    next = 1'b0;
    chk("restart r5 rcon", rcon32, 32'h1000_0000);
    chk("restart r5 round", {28'h0, round32}, 32'd5);
    do_start(2'b00, 1'b0);
    chk("restart rcon", rcon32, 32'h0100_0000);
    chk("restart round", {28'h0, round32}, 32'd1);
    chk("restart done", {31'h0, done32}, 32'h0);
    push_seq(2'b00, 1'b0);
    drain(1'b0);
    next = 1'b0;
    chk_idle("restart done pulse", 1'b1);
    // start during the DONE cycle: done already pulsing, then reload.
    push_seq(2'b01, 1'b0);
    do_start(2'b01, 1'b0);
    drain(1'b0);
    next = 1'b0;
    chk_idle("done-start pulse", 1'b1);
    cycle();
    chk_idle("done-start idle", 1'b0);

    // Asynchronous reset at round 3 clears outputs between clock edges.
    do_start(2'b00, 1'b0);
    next = 1'b1;
    cycle(); cycle();
    next = 1'b0;
    chk("pre-reset round", {28'h0, round32}, 32'd3);
    chk("pre-reset rcon", rcon32, 32'h0400_0000);
    #2 rst_n = 1'b0;
    #1 chk_idle("async reset", 1'b0);
    #2 rst_n = 1'b1;
    cycle(); cycle();
    chk_idle("post reset", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rcon_seq.md
# rcon_seq

Sequential round-constant generator for the AES key-expansion datapath. Replaces the fixed round-indexed lookup with a GF(2^8) stepping engine. Emits the Rcon word for each key-expansion step on a valid/next handshake, for AES-128/192/256 schedules. With the inverse feature compiled in, it also walks the sequence backwards for on-the-fly decryption key schedules.

## Interface
Parameters:
- WORD_W, 32, output word width; legal values 8 or 32. Rcon byte sits in bits [WORD_W-1:WORD_W-8], all other bits zero.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new sequence; sampled in any state
- key_size  in  2  sampled with start: 00=AES-128 (10 constants), 01=AES-192 (8), 10=AES-256 (7), 11 treated as 00
- dir  in  1  sampled with start: 0=forward, 1=inverse (only when RCON_INVERSE_EN defined)
- next  in  1  consumer accepts current rcon; acts only when rcon_valid=1
- rcon  out  WORD_W  current round constant; all zeros whenever rcon_valid=0
- rcon_valid  out  1  rcon holds a live constant
- round  out  4  index of the current constant, 1..L; 0 when not valid
- last  out  1  rcon_valid and current constant is the final one of the sequence
- done  out  1  one-cycle pulse after the final constant is accepted
- busy  out  1  state is RUN

## Operation
- L = 10/8/7 per latched key_size.
- States: IDLE, RUN, DONE.
  - IDLE: outputs idle.
  - start -> RUN.
  - RUN with next and !last: step the byte; round +/- 1.
  - RUN with next and last -> DONE.
  - DONE -> IDLE unconditionally; done=1 for this one cycle.
- Forward load: byte=0x01, round=1.
- Forward step: byte = {b[6:0],0} ^ (b[7] ? 0x1B : 0x00).
  - Sequence: 01 02 04 08 10 20 40 80 1B 36.
- Inverse load: byte = last forward constant (0x36/0x80/0x40 for L=10/8/7), round=L.
- Inverse step: b[0] ? (((b^0x1B)>>1) | 0x80) : (b>>1); round decrements.
  - In inverse mode, last is asserted at round=1.
- start has priority over next in every state. start in RUN aborts the current sequence and reloads; no done pulse.
- start in DONE reloads and goes to RUN; done still pulses that cycle.
- next when rcon_valid=0 is ignored.
- key_size and dir are ignored except on a start cycle.
- Byte arithmetic is 8-bit modulo the AES polynomial 0x11B; there is no state outside the listed constants.

## Timing
- Reset: state IDLE; rcon=0, rcon_valid=0, round=0, last=0, done=0, busy=0.
- Assertion of rst_n low mid-sequence clears everything immediately; no done pulse.
- All outputs are registered.
- start at edge t: rcon_valid=1 with the first constant after edge t. Latency is 1 cycle.
- next held high: a new constant every cycle. A full AES-128 sequence occupies 10 valid cycles; done follows on the 11th.
- Stalls: with next low, rcon, round and last hold indefinitely.
- busy=1 exactly while rcon_valid=1.

## Configuration
- RCON_INVERSE_EN defined: inverse load and step logic present; dir honoured as above.
- RCON_INVERSE_EN undefined: dir port retained but ignored; all sequences run forward; inverse logic not synthesised.

## Test plan
- Forward AES-128:
  - Stimulus: reset, then start with key_size=00, next held high.
  - Expected: rcon 01000000,02000000,…,1B000000,36000000 on rounds 1..10; last on round 10; done on the following cycle; then idle zeros.
- AES-192 and AES-256 forward:
  - Stimulus: start with key_size=01, then with key_size=10.
  - Expected: 8 constants ending 80000000, and 7 constants ending 40000000, respectively; last/done at round 8 and 7.
- Stall and back-pressure:
  - Stimulus: AES-128 with next toggled pseudo-randomly.
  - Expected: each constant held while next=0; no value skipped or repeated; next while idle has no effect.
- Inverse (RCON_INVERSE_EN):
  - Stimulus: start with dir=1, key_size=00.
  - Expected: 36,1B,80,…,01 with round 10 down to 1; last at round 1.
  - Without the macro, the same stimulus yields the forward sequence.
- Restart and reset:
  - Stimulus: start again at round 5 (value 10000000).
  - Expected: next cycle shows 01000000 at round 1, with no done pulse.
  - Stimulus: rst_n low at round 3.
  - Expected: all outputs 0 asynchronously.
- WORD_W=8:
  - Stimulus: forward AES-128 sequence.
  - Expected: rcon shows 01..36 as bytes, with identical handshake timing.
